btree_search_controller: RTL and testbench

BTREE_SEARCH_CONTROLLER -- requirements
Module: btree_search_controller

---
 rtl/btree_search_controller.sv | 150 +++++++++++++++
 tb/tb_btree_search_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/btree_search_controller.sv
// B-tree lookup controller: walks 3-key/4-child blocks from ROOT until the key is found,
// a null child is reached, or the fetch budget MAX_DEPTH is used up.
module btree_search_controller #(
  parameter logic [7:0] ROOT      = 8'd1,
  parameter int         MAX_DEPTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   key,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [3:0]   data,
  output logic [3:0]   depth,
  output logic         error,
  output logic         mem_req,
  output logic [7:0]   mem_addr,
  input  logic         mem_ack,
  input  logic [127:0] mem_data
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_COMPARE, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_key;
  logic [7:0]  r_addr;
  logic [3:0]  r_depth;
  logic        r_found;
  logic [3:0]  r_data;
  logic        r_error;
  logic [55:0] r_block;

  logic [3:0]  w_key1, w_key2, w_key3;
  logic [3:0]  w_dat1, w_dat2, w_dat3;
  logic [7:0]  w_node0, w_node1, w_node2, w_node3;
  logic [2:0]  w_match;
  logic        w_hit;
  logic [3:0]  w_hit_data;
  logic [2:0]  w_gt;
  logic [7:0]  w_child;
  logic [4:0]  w_depth_inc;
  logic        w_at_limit;
  logic        w_unused_hi;

  assign w_key1  = r_block[3:0];
  assign w_key2  = r_block[7:4];
  assign w_key3  = r_block[11:8];
  assign w_dat1  = r_block[15:12];
  assign w_dat2  = r_block[19:16];
  assign w_dat3  = r_block[23:20];
  assign w_node0 = r_block[31:24];
  assign w_node1 = r_block[39:32];
  assign w_node2 = r_block[47:40];
  assign w_node3 = r_block[55:48];
  assign w_unused_hi = ^mem_data[127:56];

  assign w_match    = {r_key == w_key3, r_key == w_key2, r_key == w_key1};
  assign w_hit      = |w_match;
  assign w_hit_data = (w_match[0] ? w_dat1 : 4'd0) | (w_match[1] ? w_dat2 : 4'd0) |
                      (w_match[2] ? w_dat3 : 4'd0);
  assign w_gt       = {r_key > w_key3, r_key > w_key2, r_key > w_key1};

  // Only monotone gt patterns select a child; anything else means a malformed block.
  always_comb begin
    w_child = 8'd0;
    case (w_gt)
      3'b000:  w_child = w_node0;
      3'b001:  w_child = w_node1;
      3'b011:  w_child = w_node2;
      3'b111:  w_child = w_node3;
      default: w_child = 8'd0;
    endcase
  end

  assign w_depth_inc = {1'b0, r_depth} + 5'd1;
  assign w_at_limit  = (w_depth_inc == 5'(MAX_DEPTH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_FETCH;
      S_FETCH:   if (mem_ack) w_next = S_COMPARE;
      S_COMPARE: begin
        if (w_hit || (w_child == 8'd0) || w_at_limit) w_next = S_DONE;
        else                                          w_next = S_FETCH;
      end
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_key   <= 4'd0;
      r_addr  <= 8'd0;
      r_depth <= 4'd0;
      r_found <= 1'b0;
      r_data  <= 4'd0;
      r_error <= 1'b0;
      r_block <= 56'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key   <= key;
            r_addr  <= ROOT;
            r_depth <= 4'd0;
            r_found <= 1'b0;
            r_data  <= 4'd0;
            r_error <= 1'b0;
          end
        end
        S_FETCH: begin
          if (mem_ack) r_block <= mem_data[55:0];
        end
        S_COMPARE: begin
          if (w_hit) begin
            r_found <= 1'b1;
            r_data  <= w_hit_data;
          end else if (w_child == 8'd0) begin
            r_found <= 1'b0;
          end else if (w_at_limit) begin
            r_error <= 1'b1;
          end else begin
            r_addr  <= w_child;
            r_depth <= w_depth_inc[3:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state == S_FETCH) || (r_state == S_COMPARE);
  assign done     = (r_state == S_DONE);
  assign mem_req  = (r_state == S_FETCH);
  assign mem_addr = (r_state == S_FETCH) ? r_addr : 8'd0;
  assign found    = r_found;
  assign data     = r_data;
  assign depth    = r_depth;
  assign error    = r_error;

endmodule

// File: tb/tb_btree_search_controller.sv
// Directed bench for btree_search_controller: table of searches plus stall/reset and busy-start sequences.
module tb_btree_search_controller;

  logic         clock;
  logic         reset;
  logic         start;
  logic [3:0]   key;
  logic         busy, done, found, error, mem_req;
  logic [3:0]   data, depth;
  logic [7:0]   mem_addr;
  logic         mem_ack;
  logic [127:0] mem_data;

  logic [127:0] mem [0:255];
  int ack_wait;
  logic ack_force;
  int fetch_cnt;
  logic [7:0] last_addr;
  int n_checks, n_err;

  typedef struct {
    logic [3:0] k;
    int         w;
    logic       fnd;
    logic [3:0] dat;
    logic [3:0] dep;
    logic       err;
    int         nf;
    logic [7:0] last;
  } vec_t;

  vec_t vecs[8];

  btree_search_controller #(.ROOT(8'd1), .MAX_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .start(start), .key(key),
    .busy(busy), .done(done), .found(found), .data(data), .depth(depth), .error(error),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: answers a request after ack_wait idle FETCH cycles.
  int wait_cnt = 0;
  always @(negedge clock) begin
    if (mem_req) begin
      if (wait_cnt >= ack_wait) begin
        mem_ack   = 1'b1;
        mem_data  = mem[mem_addr];
        last_addr = mem_addr;
        fetch_cnt = fetch_cnt + 1;
        wait_cnt  = 0;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      mem_ack  = ack_force;
      mem_data = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
      wait_cnt = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    int fc0;
    bit got;
    ack_wait = v.w;
    fc0 = fetch_cnt;
    @(negedge clock);
    key   = v.k;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    chk($sformatf("v%0d busy_after_start", idx), busy, 1);
    cyc = 1;
    got = 0;
    while (!got && cyc < 200) begin
      @(posedge clock);
      #1 cyc++;
      if (done) got = 1;
    end
    if (!got) begin
      chk($sformatf("v%0d done_timeout", idx), 0, 1);
    end else begin
      chk($sformatf("v%0d latency", idx), cyc, 1 + v.nf * (2 + v.w));
      chk($sformatf("v%0d found", idx), found, v.fnd);
      chk($sformatf("v%0d data", idx), data, v.dat);
      chk($sformatf("v%0d depth", idx), depth, v.dep);
      chk($sformatf("v%0d error", idx), error, v.err);
      chk($sformatf("v%0d busy_in_done", idx), busy, 0);
      chk($sformatf("v%0d fetches", idx), fetch_cnt - fc0, v.nf);
      chk($sformatf("v%0d last_addr", idx), last_addr, v.last);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d done_one_cycle", idx), done, 0);
      chk($sformatf("v%0d found_held", idx), found, v.fnd);
    end
  endtask

  initial begin
    int cyc;
    bit got;
    int fc0;
    vec_t lg;
    n_checks  = 0;
    n_err     = 0;
    fetch_cnt = 0;
    last_addr = 8'd0;
    ack_wait  = 0;
    ack_force = 1'b0;
    start     = 1'b0;
    key       = 4'd0;
    mem_ack   = 1'b0;
    mem_data  = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[1] = 128'h0006050403A87952;   // keys 2,5,9 data 7,8,A nodes 3,4,5,6
    mem[4] = 128'h0000000000421133;   // keys 3,3,1 data 1,2,4: double match
    mem[5] = 128'h000000000000C006;   // key1=6 data1=C, null children
    mem[6] = 128'h0007070707000F2C;   // keys C,2,F: non-monotone gt for key A

    vecs[0] = '{4'h5, 0, 1'b1, 4'h8, 4'd0, 1'b0, 1, 8'd1};
    vecs[1] = '{4'h2, 1, 1'b1, 4'h7, 4'd0, 1'b0, 1, 8'd1};
    vecs[2] = '{4'h9, 2, 1'b1, 4'hA, 4'd0, 1'b0, 1, 8'd1};
    vecs[3] = '{4'h6, 0, 1'b1, 4'hC, 4'd1, 1'b0, 2, 8'd5};
    vecs[4] = '{4'h7, 1, 1'b0, 4'h0, 4'd1, 1'b0, 2, 8'd5};
    vecs[5] = '{4'h3, 0, 1'b1, 4'h3, 4'd1, 1'b0, 2, 8'd4};
    vecs[6] = '{4'hA, 0, 1'b0, 4'h0, 4'd1, 1'b0, 2, 8'd6};
    vecs[7] = '{4'h1, 0, 1'b0, 4'h0, 4'd1, 1'b0, 2, 8'd3};

    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst found", found, 0);
    chk("rst data", data, 0);
    chk("rst depth", depth, 0);
    chk("rst error", error, 0);
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_addr", mem_addr, 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Self-referencing root: every descent returns to block 1 until the fetch budget ends.
    mem[1][55:48] = 8'h01;
    lg = '{4'hF, 0, 1'b0, 4'h0, 4'd3, 1'b1, 4, 8'd1};
    run_vec(lg, 100);
    mem[1][55:48] = 8'h06;

    // Stalled fetch, then asynchronous reset in the middle of it.
    ack_wait = 1000;
    fc0 = fetch_cnt;
    @(negedge clock);
    key   = 4'h5;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d mem_req", i), mem_req, 1);
      chk($sformatf("stall%0d mem_addr", i), mem_addr, 8'd1);
      @(posedge clock);
      #1;
    end
    chk("stall no fetch", fetch_cnt - fc0, 0);
    #2 reset = 1'b1;
    #1;
    chk("async rst mem_req", mem_req, 0);
    chk("async rst busy", busy, 0);
    chk("async rst mem_addr", mem_addr, 0);
    chk("async rst found", found, 0);
    chk("async rst depth", depth, 0);
    @(negedge clock);
    reset     = 1'b0;
    ack_wait  = 0;
    ack_force = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      chk($sformatf("post_rst%0d done", i), done, 0);
      chk($sformatf("post_rst%0d busy", i), busy, 0);
    end
    ack_force = 1'b0;
    run_vec(vecs[0], 200);

    // start with a different key while busy, and start during DONE, must both be ignored.
    ack_wait = 3;
    @(negedge clock);
    key   = 4'h5;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    key   = 4'h2;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    cyc = 2;
    got = 0;
    while (!got && cyc < 200) begin
      @(posedge clock);
      #1 cyc++;
      if (done) got = 1;
    end
    chk("busy_start done seen", got, 1);
    chk("busy_start latency", cyc, 1 + 1 * (2 + 3));
    chk("busy_start found", found, 1);
    chk("busy_start data", data, 4'h8);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    chk("done_start busy", busy, 0);
    chk("done_start done", done, 0);
    @(posedge clock);
    #1;
    chk("done_start idle", busy, 0);
    chk("done_start data held", data, 4'h8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
